// File: rtl/nbr_pkg.sv
// Shared constants, lane record and bank hash for neighbor_bank_router.
// lane_t widths follow the localparams here, so keep them in step with the top's parameters.
package nbr_pkg;
    localparam int LANE_COUNT = 8;
    localparam int BANK_COUNT = 32;
    localparam int TILE_SIZE  = 256;
    localparam int DATA_WIDTH = 8;
    localparam int ROW_SKEW   = 3;
    localparam int CNT_WIDTH  = 16;
    localparam int AW         = $clog2(TILE_SIZE);

    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         row;
        logic [AW-1:0]         col;
        logic [DATA_WIDTH-1:0] data;
    } lane_t;

    // Skewed bank index, evaluated at 32 bits so the row product never wraps early.
    function automatic int unsigned bank_hash(input int unsigned row, input int unsigned col,
                                              input int unsigned skew, input int unsigned banks);
        return (col + ((row * skew) % banks)) % banks;
    endfunction
endpackage

// File: rtl/nbr_bank_arbiter.sv
// Combinational per-bank arbitration: the lowest-index candidate lane targeting a bank wins it.
module nbr_bank_arbiter #(
    parameter int LANE_COUNT = 8,
    parameter int BANK_COUNT = 32,
    localparam int BANK_W = $clog2(BANK_COUNT),
    localparam int LANE_W = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1
) (
    input  logic [LANE_COUNT-1:0]             cand_valid,
    input  logic [LANE_COUNT-1:0][BANK_W-1:0] cand_bank,
    output logic [LANE_COUNT-1:0]             grant,
    output logic [BANK_COUNT-1:0]             sel_valid,
    output logic [BANK_COUNT-1:0][LANE_W-1:0] sel_lane
);
    // Scanning from the top lane down lets the lowest index overwrite last.
    always_comb begin
        sel_valid = '0;
        sel_lane  = '0;
        grant     = '0;
        for (int i = LANE_COUNT - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                sel_valid[cand_bank[i]] = 1'b1;
                sel_lane[cand_bank[i]]  = LANE_W'(i);
            end
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (sel_valid[b]) begin
                grant[sel_lane[b]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/neighbor_bank_router.sv
// Neighbor bank router: spreads per-lane writes over skewed buffer banks, stalling a beat on conflicts.
// Optional NBR_SAME_ADDR_MERGE_EN folds same-address lanes into one summed write.
module neighbor_bank_router #(
    parameter int LANE_COUNT = nbr_pkg::LANE_COUNT,
    parameter int BANK_COUNT = nbr_pkg::BANK_COUNT,
    parameter int TILE_SIZE  = nbr_pkg::TILE_SIZE,
    parameter int DATA_WIDTH = nbr_pkg::DATA_WIDTH,
    parameter int ROW_SKEW   = nbr_pkg::ROW_SKEW,
    parameter int CNT_WIDTH  = nbr_pkg::CNT_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [LANE_COUNT-1:0]                          in_en,
    input  logic [LANE_COUNT-1:0][$clog2(TILE_SIZE)-1:0]   in_row,
    input  logic [LANE_COUNT-1:0][$clog2(TILE_SIZE)-1:0]   in_col,
    input  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0]          in_data,
    output logic [BANK_COUNT-1:0]                          buf_we,
    output logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0]   buf_row,
    output logic [BANK_COUNT-1:0][$clog2(TILE_SIZE)-1:0]   buf_col,
    output logic [BANK_COUNT-1:0][DATA_WIDTH-1:0]          buf_data,
    output logic [CNT_WIDTH-1:0]                           conflict_cycles
);
    import nbr_pkg::*;

    localparam int ADDR_W = $clog2(TILE_SIZE);
    localparam int BANK_W = $clog2(BANK_COUNT);
    localparam int LANE_W = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;

    lane_t                                 pend [LANE_COUNT];
    logic [LANE_COUNT-1:0]                 pend_valid;
    logic                                  accept;
    logic [LANE_COUNT-1:0]                 cand_valid;
    logic [LANE_COUNT-1:0]                 live;
    logic [LANE_COUNT-1:0]                 grant;
    logic [LANE_COUNT-1:0][ADDR_W-1:0]     cand_row;
    logic [LANE_COUNT-1:0][ADDR_W-1:0]     cand_col;
    logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] cand_data;
    logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] sum_data;
    logic [LANE_COUNT-1:0][BANK_W-1:0]     cand_bank;
    logic [BANK_COUNT-1:0]                 sel_valid;
    logic [BANK_COUNT-1:0][LANE_W-1:0]     sel_lane;

    always_comb begin
        for (int i = 0; i < LANE_COUNT; i++) begin
            pend_valid[i] = pend[i].valid;
        end
    end

    assign in_ready = ~(|pend_valid);
    assign accept   = in_valid & in_ready;

    // Leftover lanes of the current beat always take precedence over a fresh beat.
    always_comb begin
        for (int i = 0; i < LANE_COUNT; i++) begin
            if (!in_ready) begin
                cand_valid[i] = pend[i].valid;
                cand_row[i]   = pend[i].row;
                cand_col[i]   = pend[i].col;
                cand_data[i]  = pend[i].data;
            end else begin
                cand_valid[i] = accept & in_en[i];
                cand_row[i]   = in_row[i];
                cand_col[i]   = in_col[i];
                cand_data[i]  = in_data[i];
            end
            cand_bank[i] = BANK_W'(bank_hash(32'(cand_row[i]), 32'(cand_col[i]),
                                             ROW_SKEW, BANK_COUNT));
        end
    end

    always_comb begin
        live     = cand_valid;
        sum_data = cand_data;
`ifdef NBR_SAME_ADDR_MERGE_EN
        for (int j = 0; j < LANE_COUNT; j++) begin
            for (int i = j + 1; i < LANE_COUNT; i++) begin
                if (cand_valid[j] && cand_valid[i] &&
                    cand_row[i] == cand_row[j] && cand_col[i] == cand_col[j]) begin
                    live[i]     = 1'b0;
                    sum_data[j] = sum_data[j] + cand_data[i];
                end
            end
        end
`endif
    end

    nbr_bank_arbiter #(
        .LANE_COUNT (LANE_COUNT),
        .BANK_COUNT (BANK_COUNT)
    ) u_arbiter (
        .cand_valid (live),
        .cand_bank  (cand_bank),
        .grant      (grant),
        .sel_valid  (sel_valid),
        .sel_lane   (sel_lane)
    );

    // Lane fields load only on an accepted beat; pending lanes just shed their valid bit as they win.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANE_COUNT; i++) begin
                pend[i] <= '0;
            end
            buf_we          <= '0;
            buf_row         <= '0;
            buf_col         <= '0;
            buf_data        <= '0;
            conflict_cycles <= '0;
        end else begin
            for (int i = 0; i < LANE_COUNT; i++) begin
                pend[i].valid <= live[i] & ~grant[i];
                if (accept) begin
                    pend[i].row  <= cand_row[i];
                    pend[i].col  <= cand_col[i];
                    pend[i].data <= sum_data[i];
                end
            end
            for (int b = 0; b < BANK_COUNT; b++) begin
                buf_we[b]   <= sel_valid[b];
                buf_row[b]  <= sel_valid[b] ? cand_row[sel_lane[b]] : '0;
                buf_col[b]  <= sel_valid[b] ? cand_col[sel_lane[b]] : '0;
                buf_data[b] <= sel_valid[b] ? sum_data[sel_lane[b]] : '0;
            end
            if (!in_ready && conflict_cycles != '1) begin
                conflict_cycles <= conflict_cycles + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: doc/neighbor_bank_router.md
NEIGHBOR_BANK_ROUTER -- requirements
Module: neighbor_bank_router

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- LANE_COUNT, 8, neighbor input lanes.
- BANK_COUNT, 32, buffer banks; power of two, at least 2.
- TILE_SIZE, 256, row/column range; power of two.
- DATA_WIDTH, 8, value width.
- ROW_SKEW, 3, bank rotation per row.
- CNT_WIDTH, 16, conflict counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning); AW = clog2(TILE_SIZE):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, input beat offered.
- in_ready, out, 1, beat accepted when high with in_valid.
- in_en, in, LANE_COUNT, per-lane write request.
- in_row, in, LANE_COUNT x AW, per-lane row.
- in_col, in, LANE_COUNT x AW, per-lane column.
- in_data, in, LANE_COUNT x DATA_WIDTH, per-lane value.
- buf_we, out, BANK_COUNT, per-bank write enable.
- buf_row, out, BANK_COUNT x AW, per-bank row.
- buf_col, out, BANK_COUNT x AW, per-bank column.
- buf_data, out, BANK_COUNT x DATA_WIDTH, per-bank data.
- conflict_cycles, out, CNT_WIDTH, stall-cycle count.
REQ-003 Reset is synchronous and active-high, with one clock: clk, reset.

Function
REQ-004 Bank SHALL be (col + (row*ROW_SKEW mod BANK_COUNT)) mod BANK_COUNT, computed at full width before truncation.
REQ-005 Lane state SHALL be per-lane pending registers: valid, row, col, data.
REQ-006 in_ready SHALL be 1 iff no pending valid bit is set; it is combinational from registers only.
REQ-007 Candidate set SHALL be the pending lanes when any are pending; otherwise the input lanes with in_en set when in_valid && in_ready; otherwise empty.
REQ-008 Per bank, the lowest-index candidate SHALL win; losers are stored or kept pending; winners clear their pending bit.
REQ-009 Winners SHALL appear on buf_* exactly one cycle after selection; unused banks drive we=0, row/col/data=0.
REQ-010 in_valid while in_ready=0 SHALL be ignored, with no capture and no side effect.
REQ-011 in_valid with in_en=0 SHALL accept the beat and produce no writes.
REQ-012 Order guarantee: all lanes of a beat are written before any lane of the next beat.
REQ-013 Worst case SHALL be LANE_COUNT cycles per beat (all lanes one bank); in_ready is low LANE_COUNT-1 cycles.
REQ-014 conflict_cycles SHALL increment each cycle in_ready=0 and saturate at all-ones.

Reset
REQ-015 Reset SHALL clear: all pending valid bits and fields to 0; buf_we, buf_row, buf_col, buf_data to 0; conflict_cycles to 0. in_ready is 1 in the cycle after reset.
REQ-016 Reset mid-stall SHALL drop pending lanes with no further writes; reset has priority over all other events.

Configuration
REQ-017 With NBR_SAME_ADDR_MERGE_EN defined: candidates with identical row and col merge into the lowest-index lane, whose data becomes the sum mod 2^DATA_WIDTH; merged lanes clear with no retry.
REQ-018 Without NBR_SAME_ADDR_MERGE_EN: identical-address lanes are ordinary bank conflicts and are serialized per REQ-008.

Structure
REQ-019 Package nbr_pkg SHALL hold the bank-hash function and lane struct typedef (valid, row, col, data), parameterised via localparams mirrored from the module.
REQ-020 Sub-module nbr_bank_arbiter SHALL hold the combinational per-bank lowest-index arbitration: candidates in, grant vector and per-bank selection out. Registers stay in the top.

Verification (BANK_COUNT=32, ROW_SKEW=3, LANE_COUNT=8)
REQ-021 Lanes 0-7 at (r0,c0..7), data 0x10..0x17 -> next cycle buf_we[0..7]=1 with matching data; in_ready stays 1; conflict_cycles=0.
REQ-022 Lane0 (r0,c3,0xAA) and lane1 (r1,c0,0xBB), both bank 3 -> 0xAA at cycle+1 and 0xBB at cycle+2; in_ready low 1 cycle; conflict_cycles=1.
REQ-023 All 8 lanes (r0,c5) with data 1..8, no macro -> bank 5 written 8 consecutive cycles in lane order; in_ready low 7 cycles. With macro -> single write of 36 (0x24) at cycle+1.
REQ-024 Lane0 (r10,c31) -> buf_we[29]=1 with row=10, col=31 (wrap-around).
REQ-025 Start REQ-023 without the macro, assert reset at the 3rd write -> no writes after reset; in_ready=1; counter=0. A new beat offered while in_ready=0 is never written.
